// File: rtl/la_pkg.sv
// -----------------------------------------------------------------------------
// la_pkg
// Shared definitions for the logic-analyser capture block: the capture state
// encoding (also the value read back from the state register), the register
// offsets relative to the block's base address, and the trigger-location
// clamp helper.
// The "immediate" register offset exists only when LA_CAPTURE_IMMEDIATE_EN is
// defined.
// -----------------------------------------------------------------------------
package la_pkg;

    typedef enum logic [2:0] {
        ST_IDLE             = 3'd0,
        ST_MOVE_TO_POSITION = 3'd1,
        ST_IN_POSITION      = 3'd2,
        ST_CAPTURING        = 3'd3,
        ST_CAPTURED         = 3'd4
    } la_state_e;

    localparam logic [15:0] REG_STATE       = 16'd0;
    localparam logic [15:0] REG_TRIGGER_LOC = 16'd1;
    localparam logic [15:0] REG_START       = 16'd2;
    localparam logic [15:0] REG_STOP        = 16'd3;
    localparam logic [15:0] REG_WRITE_PTR   = 16'd4;
`ifdef LA_CAPTURE_IMMEDIATE_EN
    localparam logic [15:0] REG_IMMEDIATE   = 16'd5;
`endif

    // A trigger location past the end of the buffer is meaningless, so it is
    // saturated to the last buffer slot.
    function automatic logic [15:0] clamp_loc(input logic [15:0] value,
                                              input logic [15:0] max_loc);
        return (value > max_loc) ? max_loc : value;
    endfunction

endpackage

// File: rtl/la_capture_fsm.sv
// -----------------------------------------------------------------------------
// la_capture_fsm
// Capture controller for a logic analyser sample buffer. It sits on a daisy-
// chained 16-bit register bus: every bus signal is re-registered to the output
// with one cycle of latency, and reads that fall inside this block's register
// window have their read data replaced with the register value.
//
// Once started, the buffer is written every cycle at write_pointer. After
// trigger_loc pre-trigger samples the block waits for trig, then writes
// SAMPLE_DEPTH - trigger_loc post-trigger samples and parks in CAPTURED with
// write_pointer on the oldest sample until stop is written.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   trig                  registered trigger from the trigger block
//   addr_i/wdata_i/rdata_i/rw_i/valid_i   register bus in (rw_i = 1 is write)
//   addr_o/wdata_o/rdata_o/rw_o/valid_o   register bus out, one cycle later
//   bram_addr, bram_we    sample buffer write port
//
// Build option: define LA_CAPTURE_IMMEDIATE_EN to add the "immediate" register
// at BASE+5; when set, the first IN_POSITION cycle acts as a trigger.
// -----------------------------------------------------------------------------
module la_capture_fsm
    import la_pkg::*;
#(
    parameter int BASE_ADDR    = 0,
    parameter int SAMPLE_DEPTH = 1024,
    parameter int ADDR_WIDTH   = $clog2(SAMPLE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trig,
    input  logic [15:0]           addr_i,
    input  logic [15:0]           wdata_i,
    input  logic [15:0]           rdata_i,
    input  logic                  rw_i,
    input  logic                  valid_i,
    output logic [15:0]           addr_o,
    output logic [15:0]           wdata_o,
    output logic [15:0]           rdata_o,
    output logic                  rw_o,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_we
);

    localparam logic [15:0]           BASE     = 16'(BASE_ADDR);
    localparam logic [15:0]           DEPTH    = 16'(SAMPLE_DEPTH);
    localparam logic [15:0]           LAST_LOC = 16'(SAMPLE_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] WP_LAST  = ADDR_WIDTH'(SAMPLE_DEPTH - 1);
`ifdef LA_CAPTURE_IMMEDIATE_EN
    localparam logic [15:0]           LAST_OFF = REG_IMMEDIATE;
`else
    localparam logic [15:0]           LAST_OFF = REG_WRITE_PTR;
`endif

    la_state_e             state_q, state_d;
    logic [15:0]           trigger_loc_q, trigger_loc_d;
    logic [ADDR_WIDTH-1:0] write_ptr_q, write_ptr_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [15:0]           addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [15:0]           rdata_q, rdata_d;
    logic                  rw_q, rw_d;
    logic                  valid_q, valid_d;

    logic [15:0] offset;
    logic        in_window;
    logic        reg_wr;
    logic        reg_rd;
    logic        start_req;
    logic        stop_req;
    logic        sampling;
    logic        trig_eff;
    logic [15:0] post_total;
    logic [15:0] reg_rdata;

    // Offset arithmetic wraps in 16 bits, so one unsigned compare bounds the
    // window on both sides.
    assign offset     = addr_i - BASE;
    assign in_window  = valid_i && (offset <= LAST_OFF);
    assign reg_wr     = in_window && rw_i;
    assign reg_rd     = in_window && !rw_i;
    assign start_req  = reg_wr && (offset == REG_START);
    assign stop_req   = reg_wr && (offset == REG_STOP);
    assign sampling   = state_q inside {ST_MOVE_TO_POSITION, ST_IN_POSITION, ST_CAPTURING};
    assign post_total = DEPTH - trigger_loc_q;

`ifdef LA_CAPTURE_IMMEDIATE_EN
    logic immediate_q, immediate_d;
    logic in_pos_first_q, in_pos_first_d;

    // in_pos_first_q is only consulted in IN_POSITION, where it is true
    // exactly on the first cycle after arriving from another state.
    assign trig_eff = trig | (immediate_q & in_pos_first_q);

    always_comb begin
        immediate_d    = immediate_q;
        in_pos_first_d = (state_q != ST_IN_POSITION);
        if (reg_wr && (offset == REG_IMMEDIATE)) begin
            immediate_d = wdata_i[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            immediate_q    <= 1'b0;
            in_pos_first_q <= 1'b0;
        end else begin
            immediate_q    <= immediate_d;
            in_pos_first_q <= in_pos_first_d;
        end
    end
`else
    assign trig_eff = trig;
`endif

    // Register read mux; write-only registers read as zero.
    always_comb begin
        reg_rdata = '0;
        case (offset)
            REG_STATE:       reg_rdata = 16'(state_q);
            REG_TRIGGER_LOC: reg_rdata = trigger_loc_q;
            REG_WRITE_PTR:   reg_rdata = 16'(write_ptr_q);
`ifdef LA_CAPTURE_IMMEDIATE_EN
            REG_IMMEDIATE:   reg_rdata = {15'd0, immediate_q};
`endif
            default:         reg_rdata = '0;
        endcase
    end

    // Bus pass-through with in-window read substitution.
    always_comb begin
        addr_d  = addr_i;
        wdata_d = wdata_i;
        rw_d    = rw_i;
        valid_d = valid_i;
        rdata_d = reg_rd ? reg_rdata : rdata_i;
    end

    // Capture FSM. cnt_q counts pre-trigger writes in MOVE_TO_POSITION and
    // completed post-trigger samples in CAPTURING.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d       = state_q;
        trigger_loc_d = trigger_loc_q;
        write_ptr_d   = write_ptr_q;
        cnt_d         = cnt_q;

        if (sampling) begin
            write_ptr_d = (write_ptr_q == WP_LAST) ? '0 : write_ptr_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    state_d = (trigger_loc_q == 16'd0) ? ST_IN_POSITION : ST_MOVE_TO_POSITION;
                    cnt_d   = '0;
                end
                if (reg_wr && (offset == REG_TRIGGER_LOC)) begin
                    trigger_loc_d = clamp_loc(wdata_i, LAST_LOC);
                end
            end
            ST_MOVE_TO_POSITION: begin
                if (cnt_q + 16'd1 == trigger_loc_q) begin
                    state_d = ST_IN_POSITION;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_IN_POSITION: begin
                // The trigger-cycle sample is post-trigger sample 1.
                if (trig_eff) begin
                    if (post_total == 16'd1) begin
                        state_d = ST_CAPTURED;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_CAPTURING;
                        cnt_d   = 16'd1;
                    end
                end
            end
            ST_CAPTURING: begin
                if (cnt_q + 16'd1 == post_total) begin
                    state_d = ST_CAPTURED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_CAPTURED: begin
                // The last increment left write_ptr on the oldest sample.
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (stop_req) begin
            state_d     = ST_IDLE;
            write_ptr_d = '0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            trigger_loc_q <= '0;
            write_ptr_q   <= '0;
            cnt_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            rw_q          <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            trigger_loc_q <= trigger_loc_d;
            write_ptr_q   <= write_ptr_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            rw_q          <= rw_d;
            valid_q       <= valid_d;
        end
    end

    assign addr_o    = addr_q;
    assign wdata_o   = wdata_q;
    assign rdata_o   = rdata_q;
    assign rw_o      = rw_q;
    assign valid_o   = valid_q;
    assign bram_we   = sampling;
    assign bram_addr = write_ptr_q;

endmodule

// File: tb/tb_la_capture_fsm.sv
// -----------------------------------------------------------------------------
// tb_la_capture_fsm
// Directed scoreboard bench for la_capture_fsm (SAMPLE_DEPTH=8, BASE=0x20).
// Stimulus pushes the expected bus response of every transaction and the
// expected sample buffer write addresses into queues; a negedge monitor pops
// and compares whenever valid_o or bram_we is presented.
// -----------------------------------------------------------------------------
module tb_la_capture_fsm;

    localparam int          BASE_ADDR    = 'h20;
    localparam int          SAMPLE_DEPTH = 8;
    localparam int          ADDR_WIDTH   = 3;
    localparam logic [15:0] BASE         = 16'h0020;
    localparam logic [15:0] RD_IN        = 16'hBEEF;
    localparam logic [15:0] WD_RD        = 16'h5A5A;

    logic                  clk;
    logic                  rst;
    logic                  trig;
    logic [15:0]           addr_i, wdata_i, rdata_i;
    logic                  rw_i, valid_i;
    logic [15:0]           addr_o, wdata_o, rdata_o;
    logic                  rw_o, valid_o;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic                  bram_we;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        rw;
        int unsigned cyc;
    } bus_exp_t;

    bus_exp_t    exp_q[$];
    int unsigned wq[$];
    bus_exp_t    mon_e;
    int unsigned cycle = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    la_capture_fsm #(
        .BASE_ADDR   (BASE_ADDR),
        .SAMPLE_DEPTH(SAMPLE_DEPTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .trig     (trig),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .rdata_i  (rdata_i),
        .rw_i     (rw_i),
        .valid_i  (valid_i),
        .addr_o   (addr_o),
        .wdata_o  (wdata_o),
        .rdata_o  (rdata_o),
        .rw_o     (rw_o),
        .valid_o  (valid_o),
        .bram_addr(bram_addr),
        .bram_we  (bram_we)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every presented bus response and buffer write.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL bus_unexpected: addr_o 0x%0h with no transaction pending", addr_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check($sformatf("bus_rdata@%0h", mon_e.addr), rdata_o, mon_e.rdata);
                    check($sformatf("bus_addr@%0h", mon_e.addr), addr_o, mon_e.addr);
                    check($sformatf("bus_wdata_rw@%0h", mon_e.addr), {wdata_o, rw_o}, {mon_e.wdata, mon_e.rw});
                    check($sformatf("bus_latency@%0h", mon_e.addr), cycle - mon_e.cyc, 1);
                end
            end
            if (bram_we === 1'b1) begin
                if (wq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL bram_we_unexpected: write at addr %0d with none expected", bram_addr);
                end else begin
                    check("bram_addr", bram_addr, wq.pop_front());
                end
            end
        end
    end

    // One bus transaction; called just after a rising edge, returns just after
    // the edge that captured it.
    task automatic bus(input logic [15:0] a, input logic [15:0] wd, input logic rw,
                       input logic [15:0] exp_rd);
        exp_q.push_back('{addr: a, wdata: wd, rdata: exp_rd, rw: rw, cyc: cycle});
        addr_i  = a;
        wdata_i = wd;
        rw_i    = rw;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        rw_i    = 1'b0;
        addr_i  = '0;
        wdata_i = '0;
    endtask

    task automatic wr(input logic [15:0] off, input logic [15:0] d);
        bus(BASE + off, d, 1'b1, RD_IN);
    endtask

    task automatic rd(input logic [15:0] off, input logic [15:0] e);
        bus(BASE + off, WD_RD, 1'b0, e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_writes(input int first, input int n);
        for (int i = 0; i < n; i++) wq.push_back((first + i) % SAMPLE_DEPTH);
    endtask

    task automatic wait_writes(input string name, input int budget);
        for (int i = 0; i < budget && wq.size() != 0; i++) @(posedge clk);
        #1;
        check(name, wq.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with busy inputs: everything must stay at zero.
        rst     = 1'b1;
        trig    = 1'b1;
        valid_i = 1'b1;
        rw_i    = 1'b1;
        addr_i  = BASE + 16'd2;
        wdata_i = 16'hFFFF;
        rdata_i = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bus_outputs", {addr_o, wdata_o, rdata_o, rw_o, valid_o, bram_we}, '0);
        check("rst_bram_addr", bram_addr, 0);
        trig    = 1'b0;
        valid_i = 1'b0;
        rw_i    = 1'b0;
        addr_i  = '0;
        wdata_i = '0;
        rdata_i = RD_IN;
        rst     = 1'b0;

        rd(0, 0);
        rd(1, 0);
        rd(4, 0);

        // trigger_loc clamp and read-only writes.
        wr(1, 20);
        rd(1, 7);
        wr(1, 8);
        rd(1, 7);
        wr(1, 3);
        rd(1, 3);
        wr(0, 3);
        rd(0, 0);
        wr(4, 5);
        rd(4, 0);
        check("idle_we", bram_we, 0);

        // trigger_loc=3: 3 pre-trigger writes, trigger at write_pointer 5.
        expect_writes(0, 10);
        wr(2, 0);
        idle(3);
        check("in_position_we", bram_we, 1);
        rd(0, 2);
        idle(1);
        trig = 1'b1;
        idle(1);
        trig = 1'b0;
        wait_writes("loc3_writes_done", 40);
        idle(2);
        check("captured_we", bram_we, 0);
        rd(0, 4);
        rd(4, 2);
        wr(2, 0);
        rd(0, 4);
        wr(1, 5);
        rd(1, 3);
        wr(3, 0);
        rd(0, 0);
        rd(4, 0);

        // trigger_loc=0: straight to IN_POSITION, 8 post-trigger writes.
        wr(1, 0);
        rd(1, 0);
        expect_writes(0, 9);
        wr(2, 0);
        rd(0, 2);
        trig = 1'b1;
        idle(1);
        trig = 1'b0;
        wait_writes("loc0_writes_done", 40);
        idle(2);
        rd(0, 4);
        rd(4, 1);
        check("loc0_captured_we", bram_we, 0);
        wr(3, 0);
        rd(0, 0);
        rd(4, 0);

        // trigger_loc=1: trig held through MOVE_TO_POSITION, write ignored in
        // CAPTURING, then reset mid-capture.
        wr(1, 1);
        rd(1, 1);
        expect_writes(0, 6);
        wr(2, 0);
        trig = 1'b1;
        idle(2);
        trig = 1'b0;
        wr(1, 2);
        rd(1, 1);
        rd(0, 3);
        idle(1);
        check("pre_reset_writes", wq.size(), 0);
        rst = 1'b1;
        #1;
        check("mid_rst_we", bram_we, 0);
        check("mid_rst_bram_addr", bram_addr, 0);
        check("mid_rst_rdata", rdata_o, 0);
        check("mid_rst_valid_addr", {valid_o, addr_o}, 0);
        idle(1);
        rst = 1'b0;
        rd(0, 0);
        rd(4, 0);
        rd(1, 0);

        // Out-of-window reads pass rdata_i through.
        bus(BASE + 16'd9, WD_RD, 1'b0, RD_IN);
        bus(BASE - 16'd1, WD_RD, 1'b0, RD_IN);
`ifdef LA_CAPTURE_IMMEDIATE_EN
        wr(5, 1);
        rd(5, 1);
        expect_writes(0, 8);
        wr(2, 0);
        wait_writes("immediate_writes_done", 40);
        idle(2);
        rd(0, 4);
        rd(4, 0);
`else
        rd(5, RD_IN);
        wr(5, 1);
        rd(5, RD_IN);
`endif

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        check("bus_drained", exp_q.size(), 0);
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/la_capture_fsm.md
LA_CAPTURE_FSM -- requirements
Module: la_capture_fsm

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 0: first address of this block's register window on the 16-bit register bus chain.
REQ-002 SHALL have parameter SAMPLE_DEPTH, default 1024: sample buffer depth; legal range 2..65535.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(SAMPLE_DEPTH): width of the buffer address.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, with ports in this order:
- clk  input  1  sole clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- trig  input  1  registered trigger from the upstream trigger block.
- addr_i  input  16  bus address in.
- wdata_i  input  16  bus write data in.
- rdata_i  input  16  bus read data in.
- rw_i  input  1  bus direction in; 1 = write.
- valid_i  input  1  bus transaction valid in.
- addr_o, wdata_o, rdata_o  output  16 each  registered bus pass-through.
- rw_o, valid_o  output  1 each  registered bus pass-through.
- bram_addr  output  ADDR_WIDTH  sample buffer write address.
- bram_we  output  1  sample buffer write enable.

Function
REQ-005 SHALL register all bus outputs from their inputs with 1-cycle latency.
REQ-006 SHALL, for an in-window read (valid_i=1, rw_i=0), replace rdata_o with the zero-extended register value on the same edge.
REQ-007 SHALL implement this register map:
- BASE+0  state  RO  IDLE=0, MOVE_TO_POSITION=1, IN_POSITION=2, CAPTURING=3, CAPTURED=4.
- BASE+1  trigger_loc  RW.
- BASE+2  start  WO  writing any value requests start.
- BASE+3  stop  WO  writing any value requests stop.
- BASE+4  write_pointer  RO.
REQ-008 SHALL pass out-of-window transactions and writes to RO addresses through unchanged, with no side effect.
REQ-009 SHALL accept writes to trigger_loc only in IDLE (ignored otherwise) and clamp stored values above SAMPLE_DEPTH-1 to SAMPLE_DEPTH-1.
REQ-010 SHALL, on start in IDLE, enter MOVE_TO_POSITION, or IN_POSITION if trigger_loc=0; start in any other state is ignored.
REQ-011 SHALL assert bram_we=1 exactly in MOVE_TO_POSITION, IN_POSITION and CAPTURING, with bram_addr=write_pointer.
REQ-012 SHALL increment write_pointer every cycle that bram_we=1, wrapping from SAMPLE_DEPTH-1 to 0.
REQ-013 SHALL, in MOVE_TO_POSITION, move to IN_POSITION after exactly trigger_loc writes; trig is ignored in this state.
REQ-014 SHALL, in IN_POSITION with trig=1, write that cycle's sample as post-trigger sample 1 and go to CAPTURING, or to CAPTURED if SAMPLE_DEPTH-trigger_loc=1.
REQ-015 SHALL leave CAPTURING for CAPTURED on the edge completing post-trigger sample SAMPLE_DEPTH-trigger_loc; further trig is ignored.
REQ-016 SHALL, at CAPTURED, hold write_pointer at the oldest sample; CAPTURED is held until stop.
REQ-017 SHALL, on stop in any state, go to IDLE, clear write_pointer and all counters, and drop bram_we on the next cycle.

Reset
REQ-018 SHALL, while rst=1, asynchronously force: state=IDLE, trigger_loc=0, write_pointer=0, counters=0, bram_we=0, bram_addr=0, all bus outputs=0.
REQ-019 SHALL, when rst asserts mid-capture, abandon the capture with no partial completion.

Configuration
REQ-020 SHALL, with LA_CAPTURE_IMMEDIATE_EN defined, add RW register BASE+5 "immediate" (bit 0, reset 0); when it is 1, IN_POSITION behaves as if trig=1 on its first cycle.
REQ-021 SHALL, without LA_CAPTURE_IMMEDIATE_EN, treat BASE+5 as out-of-window (pass-through) and omit the immediate logic.

Structure
REQ-022 SHALL take the state enum encoding and register offsets from shared package la_pkg.
REQ-023 SHALL be a single module with no sub-module; the bus register decode is inline.

Verification (SAMPLE_DEPTH=8)
REQ-024 Reset mid-CAPTURING -> next sample: state=0, bram_we=0, write_pointer=0, rdata_o=0.
REQ-025 Write trigger_loc=3, start, trig held 0 -> 3 writes at addresses 0..2, then IN_POSITION with bram_we still 1; read BASE+0 returns 2.
REQ-026 From REQ-025, trig pulse with write_pointer=5 -> 5 writes at addresses 5,6,7,0,1; state=4; write_pointer=2; bram_we=0.
REQ-027 trigger_loc=0, start -> IN_POSITION on the next cycle; trig -> CAPTURED after 8 writes.
REQ-028 Write trigger_loc=20 in IDLE -> readback 7; write trigger_loc=2 during CAPTURING -> readback unchanged; stop -> IDLE, write_pointer=0.
REQ-029 Read at BASE+9 with rdata_i=0xBEEF -> rdata_o=0xBEEF one cycle later; with LA_CAPTURE_IMMEDIATE_EN and immediate=1, trigger_loc=0, start -> CAPTURED after 8 writes with no trig.
